// File: rtl/keypad_scan_debounce.sv
// Keypad row scanner with column synchroniser and press/release debounce.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe key_valid while a key is held.
module keypad_scan_debounce #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_COLS-1:0]                   cols,
    output logic [NUM_ROWS-1:0]                   rows,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code,
    output logic                                  key_valid,
    output logic                                  key_held
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int KW = $clog2(NUM_ROWS*NUM_COLS);
    localparam int DW = $clog2(SCAN_DWELL);
    localparam int BW = $clog2(DEBOUNCE_CYCLES+1);

    typedef enum logic [2:0] {
        S_SCAN, S_DEBOUNCE, S_PRESSED, S_HOLD, S_RELEASE
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_COLS-1:0] sync1_q, sync2_q;
    logic [RW-1:0]       row_q, row_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [CW-1:0]       col_q, col_d;
    logic [BW-1:0]       deb_q, deb_d;
    logic [KW-1:0]       code_q, code_d;

    logic [NUM_COLS-1:0] cols_s;
    logic [CW-1:0]       low_col;
    logic [RW-1:0]       row_next;
    logic                col_hi;
    logic                dwell_end;
    logic                deb_end;
    logic                rep_pulse;

    assign cols_s    = sync2_q;
    assign col_hi    = cols_s[col_q];
    assign row_next  = (row_q == RW'(NUM_ROWS-1)) ? '0 : row_q + 1'b1;
    assign dwell_end = (dwell_q == DW'(SCAN_DWELL-1));
    assign deb_end   = (deb_q == BW'(DEBOUNCE_CYCLES-1));

    // Lowest set column wins when several keys share the row.
    always_comb begin
        low_col = '0;
        for (int i = NUM_COLS-1; i >= 0; i--) begin
            if (cols_s[i]) low_col = CW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        col_d   = col_q;
        deb_d   = deb_q;
        code_d  = code_q;
        unique case (state_q)
            S_SCAN: begin
                if (dwell_end) begin
                    dwell_d = '0;
                    if (|cols_s) begin
                        col_d   = low_col;
                        deb_d   = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        row_d = row_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (!col_hi) begin
                    row_d   = row_next;
                    state_d = S_SCAN;
                end else if (deb_end) begin
                    code_d  = KW'(int'(row_q) * NUM_COLS + int'(col_q));
                    state_d = S_PRESSED;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_PRESSED: state_d = S_HOLD;
            S_HOLD: begin
                if (!col_hi) begin
                    deb_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (col_hi) begin
                    state_d = S_HOLD;
                end else if (deb_end) begin
                    row_d   = row_next;
                    state_d = S_SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= S_SCAN;
            row_q   <= '0;
            dwell_q <= '0;
            col_q   <= '0;
            deb_q   <= '0;
            code_q  <= '0;
        end else begin
            sync1_q <= cols;
            sync2_q <= sync1_q;
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            col_q   <= col_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW  = $clog2(RMAX+1);

    logic [RPW-1:0] rep_q, rep_d;
    logic           first_q, first_d;

    // Any exit from HOLD (including a release bounce) restarts the delay.
    always_comb begin
        rep_d     = rep_q;
        first_d   = first_q;
        rep_pulse = 1'b0;
        if (state_q != S_HOLD) begin
            rep_d   = '0;
            first_d = 1'b1;
        end else if (rep_q == (first_q ? RPW'(REPEAT_DELAY-1)
                                       : RPW'(REPEAT_PERIOD-1))) begin
            rep_d     = '0;
            first_d   = 1'b0;
            rep_pulse = col_hi;
        end else begin
            rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q   <= '0;
            first_q <= 1'b1;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign rows      = NUM_ROWS'(1) << row_q;
    assign key_code  = code_q;
    assign key_valid = (state_q == S_PRESSED) || rep_pulse;
    assign key_held  = (state_q == S_HOLD) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a 4x4 keypad model.
// Expected key codes are queued at press time and popped on each strobe.
module tb_keypad_scan_debounce;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = '0;
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    int          exp_q[$];
    int          strobe_cyc[$];

    keypad_scan_debounce dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a closed switch connects its row line to its column line.
    always_comb begin
        cols = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && rows[r]) cols[c] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid === 1'b1) begin
            check("strobe_width", {31'b0, prev_valid}, 0);
            check("strobe_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("strobe_code", key_code, exp_q.pop_front());
            strobes++;
            strobe_cyc.push_back(cyc);
        end
        prev_valid = (reset === 1'b1) && (key_valid === 1'b1);
    end

    task automatic wait_held(input logic v, input int lim, input string tag);
        int n = 0;
        while (key_held !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_held, v);
    endtask

    task automatic wait_row_start(input int r, input string tag);
        logic [3:0] tgt;
        int n = 0;
        tgt = 4'b0001 << r;
        while (rows === tgt && n < 40) begin @(negedge clk); n++; end
        while (rows !== tgt && n < 80) begin @(negedge clk); n++; end
        check(tag, rows, tgt);
    endtask

    initial begin
        int s0;
        int i0;
        #200ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int i0;
        repeat (3) @(negedge clk);
        check("rst_rows", rows, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);

        reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] er;
            er = 4'b0001 << ((k / 4) % 4);
            check("idle_scan", rows, er);
            @(negedge clk);
        end

        // Clean press of key 9, held 40 cycles.
        s0 = strobes;
        wait_row_start(2, "row2_start");
        keys[9] = 1'b1;
        exp_q.push_back(9);
        repeat (40) @(negedge clk);
        check("press9_strobes", strobes - s0, 1);
        check("press9_held", key_held, 1);
        check("press9_code", key_code, 9);
        keys[9] = 1'b0;
        repeat (8) @(negedge clk);
        check("rel9_still_held", key_held, 1);
        wait_held(1'b0, 6, "rel9_dropped");
        check("rel9_next_row", rows, 4'b1000);

        // Short bounce on key 3 is rejected.
        s0 = strobes;
        wait_row_start(0, "row0_start");
        keys[3] = 1'b1;
        repeat (6) @(negedge clk);
        keys[3] = 1'b0;
        i0 = 0;
        while (rows !== 4'b0010 && i0 < 20) begin @(negedge clk); i0++; end
        check("bounce_row1", rows, 4'b0010);
        check("bounce_held", key_held, 0);
        check("bounce_strobes", strobes - s0, 0);

        // Release bounce on key 5.
        s0 = strobes;
        wait_row_start(1, "row1_start_a");
        keys[5] = 1'b1;
        exp_q.push_back(5);
        wait_held(1'b1, 30, "k5_held");
        repeat (5) @(negedge clk);
        keys[5] = 1'b0;
        repeat (4) @(negedge clk);
        keys[5] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("relbounce_held", key_held, 1);
            @(negedge clk);
        end
        check("relbounce_strobes", strobes - s0, 1);
        keys[5] = 1'b0;
        wait_held(1'b0, 20, "k5_released");

        // Two keys in row 1: lowest column wins.
        s0 = strobes;
        wait_row_start(1, "row1_start_b");
        keys[5] = 1'b1;
        keys[6] = 1'b1;
        exp_q.push_back(5);
        wait_held(1'b1, 30, "dual_held");
        check("dual_code", key_code, 5);
        check("dual_strobes", strobes - s0, 1);
        keys[5] = 1'b0;
        keys[6] = 1'b0;
        wait_held(1'b0, 20, "dual_released");

        // Reset asserted while debouncing key 10.
        s0 = strobes;
        wait_row_start(2, "row2_start_b");
        keys[10] = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_rows", rows, 4'b0001);
        check("midrst_valid", key_valid, 0);
        check("midrst_held", key_held, 0);
        check("midrst_code", key_code, 0);
        repeat (3) @(negedge clk);
        keys[10] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_strobes", strobes - s0, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
        s0 = strobes;
        wait_row_start(0, "row0_start_rep");
        i0 = strobe_cyc.size();
        keys[0] = 1'b1;
        repeat (5) exp_q.push_back(0);
        repeat (130) @(negedge clk);
        keys[0] = 1'b0;
        wait_held(1'b0, 30, "rep_released");
        check("rep_strobes", strobes - s0, 5);
        if (strobe_cyc.size() >= i0 + 5) begin
            check("rep_gap0", strobe_cyc[i0+1] - strobe_cyc[i0], 64);
            check("rep_gap1", strobe_cyc[i0+2] - strobe_cyc[i0+1], 16);
            check("rep_gap2", strobe_cyc[i0+3] - strobe_cyc[i0+2], 16);
            check("rep_gap3", strobe_cyc[i0+4] - strobe_cyc[i0+3], 16);
        end
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
